// File: rtl/ov7670_roi_capture.sv
// OV7670 byte-stream capture: synchronises the camera bus, turns byte pairs into grey
// pixels (optionally thresholded inside an ROI) and emits decimated frame-buffer writes.
module ov7670_roi_capture #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int DECIM_LOG2    = 0,
  parameter int OUT_W         = 8,
  parameter int ADDR_W        = 19,
  parameter int Y_ON_ODD_BYTE = 1
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        din,
  input  logic              arm,
  input  logic              continuous,
  input  logic [1:0]        mode,
  input  logic [7:0]        thresh,
  input  logic [9:0]        box_left,
  input  logic [9:0]        box_right,
  input  logic [9:0]        box_up,
  input  logic [9:0]        box_down,
  output logic [ADDR_W-1:0] addr,
  output logic [OUT_W-1:0]  dout,
  output logic              we,
  output logic              busy,
  output logic              capture_end,
  output logic [15:0]       frame_cnt,
  output logic              line_err,
  output logic              frame_err
);

  localparam logic [15:0] H_LIM  = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM  = 16'(V_ACTIVE);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] D_MASK = 16'((1 << DECIM_LOG2) - 1);
  localparam logic [31:0] H_DEC  = 32'(H_ACTIVE >> DECIM_LOG2);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE, DONE} state_t;
  state_t state;

  logic       vsync_s1, vsync_s2, href_s1, href_s2;
  logic [7:0] din_s1, din_s2;
  logic       vsync_rise, href_rise, href_fall;

  logic [15:0] x_reg, y_reg;
  logic        phase_reg;
  logic [7:0]  byte0_reg;
  logic [1:0]  mode_reg;
  logic [7:0]  thresh_reg;
  logic [9:0]  left_reg, right_reg, up_reg, down_reg;

  logic [7:0]        luma, r8, g8, b8, pixel;
  logic [10:0]       grey_sum;
  logic              inside_roi, wr_ok, pix_done;
  logic [15:0]       x_after;
  logic [ADDR_W-1:0] addr_calc;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      href_s1  <= 1'b0;
      href_s2  <= 1'b0;
      din_s1   <= 8'd0;
      din_s2   <= 8'd0;
    end else begin
      vsync_s1 <= vsync;
      vsync_s2 <= vsync_s1;
      href_s1  <= href;
      href_s2  <= href_s1;
      din_s1   <= din;
      din_s2   <= din_s1;
    end
  end

  assign vsync_rise = vsync_s1 & ~vsync_s2;
  assign href_rise  = href_s1 & ~href_s2;
  assign href_fall  = ~href_s1 & href_s2;

  // The second byte of a pair is still in din_s2 when the pixel completes.
  always_comb begin
    luma       = (Y_ON_ODD_BYTE != 0) ? din_s2 : byte0_reg;
    r8         = {byte0_reg[7:3], byte0_reg[7:5]};
    g8         = {byte0_reg[2:0], din_s2[7:5], byte0_reg[2:1]};
    b8         = {din_s2[4:0], din_s2[4:2]};
    grey_sum   = {2'b00, r8, 1'b0} + {1'b0, g8, 2'b00} + {3'b000, g8} + {3'b000, b8};
    inside_roi = (x_reg >= {6'd0, left_reg}) && (x_reg < {6'd0, right_reg}) &&
                 (y_reg >= {6'd0, up_reg})   && (y_reg < {6'd0, down_reg});
    case (mode_reg)
      2'd1:    pixel = inside_roi ? ((luma >= thresh_reg) ? 8'hFF : 8'h00) : luma;
      2'd2:    pixel = grey_sum[10:3];
      default: pixel = luma;
    endcase
    pix_done  = href_s2 && phase_reg;
    wr_ok     = (x_reg < H_LIM) && (y_reg < V_LIM) &&
                ((x_reg & D_MASK) == 16'd0) && ((y_reg & D_MASK) == 16'd0);
    x_after   = (pix_done && (x_reg < H_LIM)) ? x_reg + 16'd1 : x_reg;
    addr_calc = ADDR_W'(32'(y_reg >> DECIM_LOG2) * H_DEC + 32'(x_reg >> DECIM_LOG2));
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      dout        <= '0;
      we          <= 1'b0;
      busy        <= 1'b0;
      capture_end <= 1'b0;
      frame_cnt   <= 16'd0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      x_reg       <= 16'd0;
      y_reg       <= 16'd0;
      phase_reg   <= 1'b0;
      byte0_reg   <= 8'd0;
      mode_reg    <= 2'd0;
      thresh_reg  <= 8'd0;
      left_reg    <= 10'd0;
      right_reg   <= 10'd0;
      up_reg      <= 10'd0;
      down_reg    <= 10'd0;
    end else begin
      we          <= 1'b0;
      capture_end <= 1'b0;
      // A vsync rise (re)starts the frame and wins over any href edge this cycle.
      if (vsync_rise && (state == WAIT_FRAME || (state == ACTIVE && y_reg < V_LIM))) begin
        if (state == ACTIVE) frame_err <= 1'b1;
        state      <= ACTIVE;
        x_reg      <= 16'd0;
        y_reg      <= 16'd0;
        phase_reg  <= 1'b0;
        mode_reg   <= mode;
        thresh_reg <= thresh;
        left_reg   <= box_left;
        right_reg  <= box_right;
        up_reg     <= box_up;
        down_reg   <= box_down;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state     <= WAIT_FRAME;
              busy      <= 1'b1;
              line_err  <= 1'b0;
              frame_err <= 1'b0;
            end
          end
          WAIT_FRAME: begin
            busy <= 1'b1;
          end
          ACTIVE: begin
            if (href_rise) begin
              x_reg     <= 16'd0;
              phase_reg <= 1'b0;
            end else if (href_s2) begin
              phase_reg <= ~phase_reg;
              if (!phase_reg) begin
                byte0_reg <= din_s2;
              end else begin
                x_reg <= x_after;
                if (wr_ok) begin
                  we   <= 1'b1;
                  addr <= addr_calc;
                  dout <= pixel[7 -: OUT_W];
                end
              end
            end
            // The last byte of a line may complete in the same cycle the fall is seen.
            if (href_fall) begin
              if (x_after != H_LIM) line_err <= 1'b1;
              y_reg <= y_reg + 16'd1;
              if (y_reg == V_LAST) begin
                state       <= DONE;
                capture_end <= 1'b1;
                frame_cnt   <= frame_cnt + 16'd1;
              end
            end
          end
          DONE: begin
            state <= continuous ? WAIT_FRAME : IDLE;
            busy  <= continuous;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
